// File: rtl/hazard_ctrl.sv
`default_nettype none
// hazard_ctrl: operand forwarding, load-use / mul-div / memory-wait stalls and branch flush for a 5-stage pipeline.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters. Rev 1.0
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1d,
  input  logic [REG_AW-1:0] rs2d,
  input  logic [REG_AW-1:0] rs1e,
  input  logic [REG_AW-1:0] rs2e,
  input  logic [REG_AW-1:0] rde,
  input  logic [REG_AW-1:0] rdm,
  input  logic [REG_AW-1:0] rdw,
  input  logic              regwritem,
  input  logic              regwritew,
  input  logic              resultsrce0,
  input  logic              pcsrce,
  input  logic              md_start_e,
  input  logic              md_done,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  output logic [1:0]        forwardae,
  output logic [1:0]        forwardbe,
  output logic              stallf,
  output logic              stalld,
  output logic              stalle,
  output logic              stallm,
  output logic              flushd,
  output logic              flushe,
  output logic              flushm,
  output logic              flushw,
  output logic              busy
`ifdef HAZ_PERF_CNT_EN
  ,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int LC_W = $clog2(LOAD_LAT + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LDWAIT = 2'd1,
    MDWAIT = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [LC_W-1:0] r_cnt, w_cnt_nxt;
  logic            w_memwait, w_lduse;
  logic            w_sf, w_sd, w_se, w_sm, w_fd, w_fe, w_fm, w_fw;

  assign w_memwait = dmem_req_m && !dmem_ready;
  assign w_lduse   = resultsrce0 && (rde != '0) && ((rde == rs1d) || (rde == rs2d));

  // Forwarding is gated by reset so every output reads zero while rst_n is low.
  always_comb begin
    forwardae = 2'b00;
    forwardbe = 2'b00;
    if (rst_n) begin
      if (regwritem && (rs1e != '0) && (rs1e == rdm))      forwardae = 2'b10;
      else if (regwritew && (rs1e != '0) && (rs1e == rdw)) forwardae = 2'b01;
      if (regwritem && (rs2e != '0) && (rs2e == rdm))      forwardbe = 2'b10;
      else if (regwritew && (rs2e != '0) && (rs2e == rdw)) forwardbe = 2'b01;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sf = 1'b0; w_sd = 1'b0; w_se = 1'b0; w_sm = 1'b0;
    w_fd = 1'b0; w_fe = 1'b0; w_fm = 1'b0; w_fw = 1'b0;
    if (w_memwait) begin
      w_sf = 1'b1; w_sd = 1'b1; w_se = 1'b1; w_sm = 1'b1;
      w_fw = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_lduse) begin
            w_sf = 1'b1; w_sd = 1'b1; w_fe = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = LDWAIT;
              w_cnt_nxt   = LC_W'(LOAD_LAT - 1);
            end
          end else if (md_start_e && !md_done) begin
            w_sf = 1'b1; w_sd = 1'b1; w_se = 1'b1; w_fm = 1'b1;
            w_state_nxt = MDWAIT;
          end
        end
        LDWAIT: begin
          w_sf = 1'b1; w_sd = 1'b1; w_fe = 1'b1;
          w_cnt_nxt = r_cnt - LC_W'(1);
          if (r_cnt == LC_W'(1)) w_state_nxt = RUN;
        end
        MDWAIT: begin
          if (md_done) begin
            w_state_nxt = RUN;
          end else begin
            w_sf = 1'b1; w_sd = 1'b1; w_se = 1'b1; w_fm = 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
      // A taken branch discards the dependent instruction, so it cancels any load-use hold.
      if (pcsrce && !w_se) begin
        w_fd = 1'b1; w_fe = 1'b1;
        w_sf = 1'b0; w_sd = 1'b0;
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign stallf = rst_n & w_sf;
  assign stalld = rst_n & w_sd;
  assign stalle = rst_n & w_se;
  assign stallm = rst_n & w_sm;
  assign flushd = rst_n & w_fd;
  assign flushe = rst_n & w_fe;
  assign flushm = rst_n & w_fm;
  assign flushw = rst_n & w_fw;
  assign busy   = rst_n & (r_state != RUN);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallf && (r_stall_cnt != '1))              r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((flushd || flushe) && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule
`default_nettype wire
